shift_right_seq: RTL and testbench

- Multi-cycle right shifter for the Tiny-CPU datapath; the opposite direction of the existing combinational left-shift.
- Shifts an operand right by 0..WIDTH-1 positions, one bit per clock. Logical mode fills with zero; arithmetic mode fills with the sign bit.
- Sits beside the ALU under control-unit sequencing via a start/busy/done handshake.
- Returns the result, the last bit shifted out (carry) and a zero flag.

---
 rtl/tiny_cpu_pkg.sv | 13 +
 rtl/shift_right_step.sv | 17 +
 rtl/shift_right_seq.sv | 121 ++++++++++++
 tb/tb_shift_right_seq.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/tiny_cpu_pkg.sv
// Shared Tiny-CPU definitions: the default datapath width and the shifter FSM
// state encoding.
package tiny_cpu_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_right_step.sv
// One-position right shift: the fill bit is the sign bit in arithmetic mode
// and zero otherwise. The bit that falls off the LSB end is returned as bit_out.
module shift_right_step
  import tiny_cpu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] data,
  input  logic             arith,
  output logic [WIDTH-1:0] shifted,
  output logic             bit_out
);

  assign shifted = {arith & data[WIDTH-1], data[WIDTH-1:1]};
  assign bit_out = data[0];

endmodule

// File: rtl/shift_right_seq.sv
// Multi-cycle right shifter, one bit per clock, with a start/busy/done handshake.
// result/carry/zero are published only on entry to DONE and held otherwise.
module shift_right_seq
  import tiny_cpu_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             arith,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AMT_W-1:0] amount,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
);

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   shift_reg, shift_next;
  logic [AMT_W-1:0]   cnt_reg, cnt_next;
  logic               mode_reg, mode_next;
  logic               out_bit_reg, out_bit_next;
  logic [WIDTH-1:0]   result_reg, result_next;
  logic               carry_reg, carry_next;
  logic               zero_reg, zero_next;
  logic               done_reg, done_next;

  logic [WIDTH-1:0]   step_value;
  logic               step_bit;

  shift_right_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .data    (shift_reg),
    .arith   (mode_reg),
    .shifted (step_value),
    .bit_out (step_bit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      shift_reg   <= '0;
      cnt_reg     <= '0;
      mode_reg    <= 1'b0;
      out_bit_reg <= 1'b0;
      result_reg  <= '0;
      carry_reg   <= 1'b0;
      zero_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      cnt_reg     <= cnt_next;
      mode_reg    <= mode_next;
      out_bit_reg <= out_bit_next;
      result_reg  <= result_next;
      carry_reg   <= carry_next;
      zero_reg    <= zero_next;
      done_reg    <= done_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    cnt_next     = cnt_reg;
    mode_next    = mode_reg;
    out_bit_next = out_bit_reg;
    result_next  = result_reg;
    carry_next   = carry_reg;
    zero_next    = zero_reg;
    done_next    = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          shift_next   = data_in;
          cnt_next     = amount;
          mode_next    = arith;
          out_bit_next = 1'b0;
          state_next   = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (cnt_reg == '0) begin
          // Publish on the way into DONE so outputs change exactly with done.
          state_next  = S_DONE;
          done_next   = 1'b1;
          result_next = shift_reg;
          carry_next  = out_bit_reg;
          zero_next   = (shift_reg == '0);
        end else begin
          shift_next   = step_value;
          out_bit_next = step_bit;
          cnt_next     = cnt_reg - AMT_W'(1);
        end
      end

      S_DONE: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign busy   = (state_reg != S_IDLE);
  assign done   = done_reg;
  assign result = result_reg;
  assign carry  = carry_reg;
  assign zero   = zero_reg;

endmodule

// File: tb/tb_shift_right_seq.sv
// Bench for shift_right_seq: per-cycle comparison against an operation-level
// model, plus directed operations with hand-computed results.
module tb_shift_right_seq;

  localparam int WIDTH = 8;
  localparam int AMT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             arith = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic [AMT_W-1:0] amount = '0;
  logic             busy, done, carry, zero;
  logic [WIDTH-1:0] result;

  int errors = 0;
  int checks = 0;
  int done_count = 0;

  shift_right_seq #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .arith   (arith),
    .data_in (data_in),
    .amount  (amount),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .carry   (carry),
    .zero    (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Operation-level model: an accepted op finishes at a known edge with the
  // arithmetic result of the whole shift.
  int               edge_no = 0;
  bit               m_pending = 0;
  bit               m_busy = 0;
  bit               m_done = 0;
  int               m_done_edge = 0;
  int               m_idle_edge = 0;
  logic [WIDTH-1:0] m_exp_result = '0;
  logic             m_exp_carry = 1'b0;
  logic [WIDTH-1:0] m_result = '0;
  logic             m_carry = 1'b0;
  logic             m_zero = 1'b0;

  always @(posedge clk) begin
    edge_no++;
    if (!rst_n) begin
      m_pending = 0; m_busy = 0; m_done = 0;
      m_result = '0; m_carry = 1'b0; m_zero = 1'b0;
    end else begin
      if (!m_busy && start) begin
        m_pending    = 1;
        m_done_edge  = edge_no + int'(amount) + 1;
        m_idle_edge  = edge_no + int'(amount) + 2;
        m_exp_result = arith ? WIDTH'($signed(data_in) >>> amount) : (data_in >> amount);
        m_exp_carry  = (amount == 0) ? 1'b0 : data_in[amount - AMT_W'(1)];
      end
      m_done = m_pending && (edge_no == m_done_edge);
      if (m_done) begin
        m_result = m_exp_result;
        m_carry  = m_exp_carry;
        m_zero   = (m_exp_result == '0);
      end
      m_busy = m_pending && (edge_no < m_idle_edge);
      if (m_pending && edge_no == m_idle_edge) m_pending = 0;
    end
  end

  always @(negedge clk) begin
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    chk("done", {31'd0, done}, {31'd0, m_done});
    chk("result", {24'd0, result}, {24'd0, m_result});
    chk("carry", {31'd0, carry}, {31'd0, m_carry});
    chk("zero", {31'd0, zero}, {31'd0, m_zero});
    if (done) done_count++;
  end

  task automatic run_op(input logic [7:0] d, input int amt, input logic ar,
                        input logic [7:0] exp_res, input logic exp_c, input logic exp_z,
                        input int exp_edges);
    int k;
    bit seen;
    seen = 0;
    data_in = d; amount = AMT_W'(amt); arith = ar; start = 1'b1;
    for (k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (done) begin seen = 1; break; end
    end
    chk("op_done_seen", {31'd0, seen}, 32'd1);
    if (seen) begin
      chk("op_latency", k - 1, exp_edges);
      chk("op_result", {24'd0, result}, {24'd0, exp_res});
      chk("op_carry", {31'd0, carry}, {31'd0, exp_c});
      chk("op_zero", {31'd0, zero}, {31'd0, exp_z});
    end
    $display("op d=0x%02h amt=%0d arith=%0d -> result=0x%02h carry=%0d zero=%0d",
             d, amt, ar, result, carry, zero);
    @(negedge clk);
  endtask

  initial begin
    int dc0;
    int dcyc[3];
    int nd;

    // Reset
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_result", {24'd0, result}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed operations
    run_op(8'hB4, 3, 1'b0, 8'h16, 1'b1, 1'b0, 4);
    run_op(8'hB4, 3, 1'b1, 8'hF6, 1'b1, 1'b0, 4);
    run_op(8'h80, 7, 1'b1, 8'hFF, 1'b0, 1'b0, 8);
    run_op(8'h5A, 0, 1'b0, 8'h5A, 1'b0, 1'b0, 1);
    run_op(8'h01, 1, 1'b0, 8'h00, 1'b1, 1'b1, 2);

    // Start ignored while busy, including the DONE cycle
    dc0 = done_count;
    data_in = 8'hB4; amount = 3'd3; arith = 1'b0; start = 1'b1;
    @(negedge clk);
    data_in = 8'hFF;
    repeat (5) @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("ignore_done_count", done_count - dc0, 1);
    chk("ignore_result", {24'd0, result}, 32'h16);
    $display("busy-ignore: dones=%0d result=0x%02h", done_count - dc0, result);

    // Reset in the middle of an operation
    dc0 = done_count;
    data_in = 8'hB4; amount = 3'd5; arith = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_result", {24'd0, result}, 32'd0);
    chk("midrst_carry", {31'd0, carry}, 32'd0);
    repeat (10) @(negedge clk);
    chk("midrst_no_done", done_count - dc0, 0);
    $display("mid-op reset: dones=%0d busy=%0d", done_count - dc0, busy);
    run_op(8'h40, 2, 1'b0, 8'h10, 1'b0, 1'b0, 3);

    // Back-to-back with start held high
    nd = 0;
    data_in = 8'hB4; amount = 3'd3; arith = 1'b1; start = 1'b1;
    for (int k = 1; k <= 40 && nd < 3; k++) begin
      @(negedge clk);
      if (done) begin
        dcyc[nd] = k;
        chk("b2b_result", {24'd0, result}, 32'hF6);
        nd++;
      end
    end
    start = 1'b0;
    chk("b2b_done_count", nd, 3);
    if (nd == 3) begin
      chk("b2b_spacing0", dcyc[1] - dcyc[0], 6);
      chk("b2b_spacing1", dcyc[2] - dcyc[1], 6);
    end
    $display("back-to-back: dones=%0d at cycles %0d %0d %0d", nd, dcyc[0], dcyc[1], dcyc[2]);
    repeat (12) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
